fetch_seq: RTL and testbench

- Parametrised successor to the core's program-counter/fetch sequencer: owns prog_ctr and the start/done run control.
- Supports relative and absolute jumps, plus subroutine call/return through a hardware return stack of configurable depth.
- Adds stall, a configurable halt address and an instruction-retire counter.
- Sits between the control decoder / jump-target LUT (inputs) and instr_ROM (prog_ctr output).

---
 rtl/fetch_seq.sv | 115 +++++++++++
 tb/tb_fetch_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Program-counter / fetch sequencer: run control, relative/absolute jumps,
// call/return through a hardware return stack, stall, halt address, retire count.
module fetch_seq #(
   parameter int D         = 12,
   parameter int SD        = 4,
   parameter int DONE_ADDR = 128,
   parameter int CW        = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stall,
   input  logic          reljump_en,
   input  logic          absjump_en,
   input  logic          call_en,
   input  logic          ret_en,
   input  logic [D-1:0]  target,
   output logic [D-1:0]  prog_ctr,
   output logic          busy,
   output logic          done,
   output logic          stk_ovf,
   output logic          stk_unf,
   output logic [CW-1:0] retired
);
   // state | meaning
   // IDLE  | after reset, waiting for start; everything held
   // RUN   | fetching; one prog_ctr action per non-stalled cycle
   // DONE  | prog_ctr reached DONE_ADDR; held until start or reset
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int SPW = $clog2(SD + 1);

   state_t         state;
   logic [SPW-1:0] sp;
   logic [SPW-1:0] sp_m1;
   logic [D-1:0]   stack [0:(2**SPW)-1];
   logic [D-1:0]   pc_inc;
   logic           halt;
   logic           act;
   logic           stk_full;
   logic           stk_empty;
   logic           push_en;

   assign pc_inc    = prog_ctr + D'(1);
   assign sp_m1     = sp - SPW'(1);
   // Widened compare so a DONE_ADDR beyond the counter range never matches.
   assign halt      = (64'(prog_ctr) == 64'(DONE_ADDR));
   assign stk_full  = (sp == SPW'(SD));
   assign stk_empty = (sp == '0);
   assign act       = (state == RUN) && !start && !stall && !halt;
   assign push_en   = act && !ret_en && call_en && !stk_full;

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Stack contents carry no reset; sp alone defines validity.
   always_ff @(posedge clk) begin
      if (push_en)
         stack[sp] <= pc_inc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         prog_ctr <= '0;
         sp       <= '0;
         stk_ovf  <= 1'b0;
         stk_unf  <= 1'b0;
         retired  <= '0;
      end else if (start) begin
         state    <= RUN;
         prog_ctr <= '0;
         sp       <= '0;
         stk_ovf  <= 1'b0;
         stk_unf  <= 1'b0;
         retired  <= '0;
      end else begin
         case (state)
            RUN: begin
               if (halt) begin
                  state <= DONE;
               end else if (!stall) begin
                  if (ret_en) begin
                     if (!stk_empty) begin
                        prog_ctr <= stack[sp_m1];
                        sp       <= sp_m1;
                     end else begin
                        stk_unf  <= 1'b1;
                        prog_ctr <= pc_inc;
                     end
                  end else if (call_en) begin
                     if (!stk_full) begin
                        sp       <= sp + SPW'(1);
                        prog_ctr <= target;
                     end else begin
                        stk_ovf  <= 1'b1;
                        prog_ctr <= pc_inc;
                     end
                  end else if (absjump_en) begin
                     prog_ctr <= target;
                  end else if (reljump_en) begin
                     // Two's-complement add modulo 2^D equals the sign-extended add.
                     prog_ctr <= prog_ctr + target;
                  end else begin
                     prog_ctr <= pc_inc;
                  end
                  if (retired != {CW{1'b1}})
                     retired <= retired + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: vector table plus hand sequences for halt,
// async reset and counter wrap on a narrow instance.
module tb_fetch_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stall, reljump_en, absjump_en, call_en, ret_en;
   logic [11:0] target;
   logic [11:0] prog_ctr;
   logic        busy, done, stk_ovf, stk_unf;
   logic [15:0] retired;

   logic        s_start;
   logic [3:0]  s_pc;
   logic        s_busy, s_done, s_ovf, s_unf;
   logic [15:0] s_ret;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_seq #(.D(12), .SD(4), .DONE_ADDR(128), .CW(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .reljump_en(reljump_en), .absjump_en(absjump_en), .call_en(call_en),
      .ret_en(ret_en), .target(target), .prog_ctr(prog_ctr), .busy(busy),
      .done(done), .stk_ovf(stk_ovf), .stk_unf(stk_unf), .retired(retired)
   );

   fetch_seq #(.D(4), .SD(2), .DONE_ADDR(16), .CW(16)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .stall(1'b0),
      .reljump_en(1'b0), .absjump_en(1'b0), .call_en(1'b0),
      .ret_en(1'b0), .target(4'd0), .prog_ctr(s_pc), .busy(s_busy),
      .done(s_done), .stk_ovf(s_ovf), .stk_unf(s_unf), .retired(s_ret)
   );

   typedef struct {
      logic        st, sl, rj, aj, ca, re;
      logic [11:0] tg;
      logic [11:0] pc;
      logic        bz, dn, ov, un;
      logic [15:0] rt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic st, logic sl, logic rj, logic aj, logic ca,
                               logic re, logic [11:0] tg, logic [11:0] pc,
                               logic bz, logic dn, logic ov, logic un, int rt);
      vec_t v;
      v.st = st; v.sl = sl; v.rj = rj; v.aj = aj; v.ca = ca; v.re = re;
      v.tg = tg; v.pc = pc; v.bz = bz; v.dn = dn; v.ov = ov; v.un = un;
      v.rt = 16'(rt);
      tbl.push_back(v);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; stall = 0; reljump_en = 0; absjump_en = 0;
      call_en = 0; ret_en = 0; target = '0;
   endtask

   initial begin
      int r;
      rst_n = 1'b0;
      s_start = 1'b0;
      idle_inputs();

      // Vector table: each row is one clock of stimulus and the state after it.
      r = 0;
      add(1,0,0,0,0,0, 12'd0,   12'd0,   1,0,0,0, r);
      for (int i = 1; i <= 10; i++) begin
         r++; add(0,0,0,0,0,0, 12'd0, 12'(i), 1,0,0,0, r);
      end
      r++; add(0,0,1,0,0,0, 12'hFFD, 12'd7,  1,0,0,0, r);
      r++; add(0,0,0,1,0,0, 12'd40,  12'd40, 1,0,0,0, r);
      r++; add(0,0,1,1,0,0, 12'd5,   12'd5,  1,0,0,0, r);
      r++; add(0,0,0,0,1,0, 12'd100, 12'd100,1,0,0,0, r);
      r++; add(0,0,0,0,1,0, 12'd200, 12'd200,1,0,0,0, r);
      r++; add(0,0,0,0,1,0, 12'd300, 12'd300,1,0,0,0, r);
      r++; add(0,0,0,0,1,0, 12'd400, 12'd400,1,0,0,0, r);
      r++; add(0,0,0,0,1,0, 12'd500, 12'd401,1,0,1,0, r);
      r++; add(0,0,0,0,0,1, 12'd0,   12'd301,1,0,1,0, r);
      r++; add(0,0,0,0,0,1, 12'd0,   12'd201,1,0,1,0, r);
      r++; add(0,0,0,0,0,1, 12'd0,   12'd101,1,0,1,0, r);
      r++; add(0,0,0,0,0,1, 12'd0,   12'd6,  1,0,1,0, r);
      r++; add(0,0,0,0,0,1, 12'd0,   12'd7,  1,0,1,1, r);
      r++; add(0,0,0,0,1,1, 12'd77,  12'd8,  1,0,1,1, r);
      r++; add(0,0,0,0,1,0, 12'd50,  12'd50, 1,0,1,1, r);
      r++; add(0,0,0,0,0,1, 12'd0,   12'd9,  1,0,1,1, r);
      r++; add(0,0,0,1,0,0, 12'd20,  12'd20, 1,0,1,1, r);
      for (int i = 0; i < 3; i++)
         add(0,1,1,0,0,0, 12'd5, 12'd20, 1,0,1,1, r);
      r++; add(0,0,1,0,0,0, 12'd5,   12'd25, 1,0,1,1, r);
      r++; add(0,0,0,0,1,0, 12'd60,  12'd60, 1,0,1,1, r);
      r = 0;
      add(1,0,0,0,1,0, 12'd99,  12'd0,   1,0,0,0, r);
      r++; add(0,0,0,0,0,1, 12'd0,   12'd1,  1,0,0,1, r);
      r++; add(0,0,0,1,0,0, 12'd120, 12'd120,1,0,0,1, r);
      for (int i = 121; i <= 128; i++) begin
         r++; add(0,0,0,0,0,0, 12'd0, 12'(i), 1,0,0,1, r);
      end
      add(0,1,1,0,0,0, 12'd5,   12'd128, 0,1,0,1, r);
      add(0,0,0,0,1,0, 12'd9,   12'd128, 0,1,0,1, r);

      #23;
      chk("reset_pc", 32'(prog_ctr), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_flags", {30'd0, stk_ovf, stk_unf}, 0);
      chk("reset_retired", 32'(retired), 0);
      rst_n = 1'b1;
      step();

      foreach (tbl[k]) begin
         start = tbl[k].st; stall = tbl[k].sl; reljump_en = tbl[k].rj;
         absjump_en = tbl[k].aj; call_en = tbl[k].ca; ret_en = tbl[k].re;
         target = tbl[k].tg;
         step();
         if (prog_ctr !== tbl[k].pc || busy !== tbl[k].bz || done !== tbl[k].dn ||
             stk_ovf !== tbl[k].ov || stk_unf !== tbl[k].un || retired !== tbl[k].rt) begin
            $display("FAIL vec%0d got pc=%0d b=%0b d=%0b o=%0b u=%0b r=%0d expected pc=%0d b=%0b d=%0b o=%0b u=%0b r=%0d",
                     k, prog_ctr, busy, done, stk_ovf, stk_unf, retired,
                     tbl[k].pc, tbl[k].bz, tbl[k].dn, tbl[k].ov, tbl[k].un, tbl[k].rt);
            errors++;
         end
         checks++;
      end
      idle_inputs();

      // Plain run from 0 to the halt address.
      start = 1; step(); start = 0;
      chk("run_pc0", 32'(prog_ctr), 0);
      for (int i = 1; i <= 128; i++) begin
         step();
         chk("run_pc", 32'(prog_ctr), 32'(i));
      end
      chk("run_done_at_128", 32'(done), 0);
      step();
      chk("halt_done", 32'(done), 1);
      chk("halt_busy", 32'(busy), 0);
      chk("halt_pc", 32'(prog_ctr), 128);
      chk("halt_retired", 32'(retired), 128);
      step();
      chk("halt_hold_pc", 32'(prog_ctr), 128);
      chk("halt_hold_retired", 32'(retired), 128);

      // Asynchronous reset mid-run at prog_ctr 33.
      start = 1; step(); start = 0;
      for (int i = 0; i < 33; i++) step();
      chk("pre_reset_pc", 32'(prog_ctr), 33);
      #3 rst_n = 1'b0;
      #1;
      chk("async_pc", 32'(prog_ctr), 0);
      chk("async_busy", 32'(busy), 0);
      chk("async_retired", 32'(retired), 0);
      @(negedge clk);
      rst_n = 1'b1;
      absjump_en = 1; target = 12'd50;
      step(); step();
      chk("idle_pc", 32'(prog_ctr), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      idle_inputs();

      // Narrow instance: wraps 15 -> 0, halt address unreachable.
      s_start = 1; step(); s_start = 0;
      chk("s_pc0", 32'(s_pc), 0);
      for (int i = 1; i <= 20; i++) begin
         step();
         chk("s_wrap_pc", 32'(s_pc), 32'(i % 16));
         chk("s_done", 32'(s_done), 0);
      end
      chk("s_busy", 32'(s_busy), 1);
      chk("s_retired", 32'(s_ret), 20);
      chk("s_flags", {30'd0, s_ovf, s_unf}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
